seq_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier that produces the 16-bit product shown on the four-digit hex display. It accepts two WIDTH-bit operands on a single-cycle start request and iterates one bit per clock. It registers the result on `p`, which drives the display stage's `p` input directly. `p` holds the last completed product, so the display stays stable while a new multiply runs.

---
 rtl/seq_multiplier_pkg.sv | 26 ++
 rtl/seq_multiplier.sv | 103 ++++++++++
 tb/tb_seq_multiplier.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// seq_multiplier_pkg
//   Shared definitions for the sequential shift-and-add multiplier and the
//   display stage it feeds.
//   - state_t        : two-state controller encoding (IDLE, RUN)
//   - WIDTH_DEFAULT  : default operand width (8)
//   - PRODUCT_WIDTH  : product width at the default operand width (16). The
//                      display stage sizes its p input from this value.
//   - count_width()  : iteration counter width for a given operand width
// ---------------------------------------------------------------------------
package seq_multiplier_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int PRODUCT_WIDTH = 2 * WIDTH_DEFAULT;

  // $clog2(1) is 0. A zero-width counter is illegal, so keep at least one bit.
  function automatic int count_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Unsigned shift-and-add multiplier. It processes one multiplier bit per
//   clock and always runs exactly WIDTH iterations. The product register p
//   keeps the last completed result, so the hex display stays steady while
//   the next multiply is running.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        request pulse; sampled only while idle
//   a      in   WIDTH    multiplicand, unsigned; captured with the request
//   b      in   WIDTH    multiplier, unsigned; captured with the request
//   busy   out  1        multiply in progress
//   done   out  1        one-cycle pulse: p was updated on the last edge
//   p      out  2*WIDTH  product of the last completed multiply
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// block is idle (busy=0). a and b are captured on that edge and may change
// freely afterwards. A start seen while busy=1 is dropped and has no effect.
// WIDTH edges after acceptance, p carries the new product and done is high
// for exactly one cycle. busy and done are never high together. A start
// presented during the done cycle is accepted, because the block is already
// idle at that point. All outputs come straight from registers.
// ---------------------------------------------------------------------------
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   count;

  // Accumulator value after this cycle's conditional add. On the final
  // iteration p must include that add, so p is loaded from this sum rather
  // than from acc.
  logic [PW-1:0]   acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      // done is a single-cycle pulse. Clearing it by default ends the pulse
      // on the edge after completion.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            p     <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int LAT = W;
  localparam int TIMEOUT = 20;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int exp_dones = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Every done pulse pops one expected product and compares it with p.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      check("busy_low_at_done", {31'b0, busy}, 32'd0);
      check("done_was_expected", {31'b0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        check("product", {16'b0, p}, {16'b0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a falling edge. Returns at the falling edge after the accepting
  // rising edge.
  task automatic start_mult(input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_result);
    a = x;
    b = y;
    start = 1'b1;
    if (expect_result) begin
      exp_q.push_back(PW'(x) * PW'(y));
      exp_dones++;
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("no_done_after_accept", {31'b0, done}, 32'd0);
  endtask

  // Called right after start_mult. Waits until done is high, or until the
  // cycle budget runs out, and checks latency and that p held meanwhile.
  task automatic wait_done(input string tag);
    logic [PW-1:0] p0;
    int  cyc;
    bit  stable;
    p0 = p;
    cyc = 0;
    stable = 1'b1;
    while (!done && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (!done && p !== p0) stable = 1'b0;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_p_stable_before_done"}, {31'b0, stable}, 32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    vecs[0] = '{8'h0F, 8'h0F, 16'h00E1};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hAB, 16'h0000};
    vecs[3] = '{8'hAB, 8'h00, 16'h0000};
    vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[5] = '{8'h80, 8'h80, 16'h4000};
    vecs[6] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[7] = '{8'h0D, 8'h0B, 16'h008F};
    for (int i = 8; i < NV; i++) begin
      vecs[i].a = W'($urandom_range(0, 255));
      vecs[i].b = W'($urandom_range(0, 255));
      vecs[i].p = PW'(vecs[i].a) * PW'(vecs[i].b);
    end

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    // ---- reset and idle ----
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_p", {16'b0, p}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold", {14'b0, busy, done, p}, 32'd0);
    end

    // ---- table-driven products ----
    for (int i = 0; i < NV; i++) begin
      start_mult(vecs[i].a, vecs[i].b, 1'b1);
      wait_done("vec");
      @(negedge clk);
      check("done_single_pulse", {31'b0, done}, 32'd0);
      check("idle_after_done", {31'b0, busy}, 32'd0);
      check("p_hold_after_done", {16'b0, p}, {16'b0, vecs[i].p});
    end

    // ---- start while busy is ignored ----
    begin
      int c;
      int dc0;
      dc0 = done_cnt;
      start_mult(8'h03, 8'h05, 1'b1);   // after edge k
      repeat (2) @(negedge clk);        // after edge k+2
      a = 8'h07;
      b = 8'h07;
      start = 1'b1;
      @(negedge clk);                   // after edge k+3
      start = 1'b0;
      check("busy_ignores_start", {31'b0, busy}, 32'd1);
      c = 3;
      while (!done && c < TIMEOUT) begin
        @(negedge clk);
        c++;
      end
      check("busy_drop_latency", c, LAT);
      check("busy_low_after_ignored", {31'b0, busy}, 32'd0);
      repeat (12) @(negedge clk);
      check("single_done_ignored_start", done_cnt - dc0, 1);
      check("p_after_ignored_start", {16'b0, p}, 32'h000F);
    end

    // ---- back-to-back: start in the done cycle ----
    start_mult(8'h12, 8'h34, 1'b1);
    wait_done("b2b_first");
    check("b2b_first_p", {16'b0, p}, 32'h03A8);
    start_mult(8'h02, 8'h03, 1'b1);
    wait_done("b2b_second");
    check("b2b_second_p", {16'b0, p}, 32'h0006);
    @(negedge clk);

    // ---- reset mid-operation ----
    begin
      int dc0;
      dc0 = done_cnt;
      start_mult(8'hAA, 8'h55, 1'b0);   // after edge k
      repeat (3) @(negedge clk);        // after edge k+3, iteration 4 next
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_done", {31'b0, done}, 32'd0);
      check("midrst_p", {16'b0, p}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("midrst_no_done", done_cnt - dc0, 0);
      check("midrst_p_held", {16'b0, p}, 32'd0);
      start_mult(8'h02, 8'h02, 1'b1);
      wait_done("post_reset");
      check("post_reset_p", {16'b0, p}, 32'h0004);
      @(negedge clk);
    end

    // ---- final report ----
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt, exp_dones);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
